mul_share_sched: RTL and testbench

MUL_SHARE_SCHED -- requirements
Module: mul_share_sched

---
 rtl/mul_share_sched.sv | 134 +++++++++++++
 tb/tb_mul_share_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_sched.sv
// rtl/mul_share_sched.sv - round-robin scheduler sharing one multiplier among NREQ requesters
module mul_share_sched #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NREQ-1:0]                     req_valid,
    output logic [NREQ-1:0]                     req_ready,
    input  logic [NREQ-1:0][WIDTH-1:0]          req_a,
    input  logic [NREQ-1:0][WIDTH-1:0]          req_b,
    output logic [WIDTH-1:0]                    mul_in1,
    output logic [WIDTH-1:0]                    mul_in2,
    input  logic [2*WIDTH:0]                    mul_out,
    output logic                                resp_valid,
    input  logic                                resp_ready,
    output logic [$clog2(NREQ)-1:0]             resp_id,
    output logic [2*WIDTH-1:0]                  resp_data,
    output logic                                resp_ovf,
    output logic [15:0]                         op_count
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IDW-1:0]  rr_ptr;
    logic [3:0]      lat_cnt;
    logic            armed;
    logic            gnt_any;
    logic [IDW-1:0]  gnt_idx;
    logic            accept;
    logic            resp_hs;

    // First valid requester at or after rr_ptr, searching upward with wrap.
    // Iterating from the farthest offset down lets the nearest one win.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
    end

    // Next-state logic and the one-hot accept strobe toward requesters.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_any && armed) begin
                    req_ready[gnt_idx] = 1'b1;
                    accept             = 1'b1;
                    state_next         = BUSY;
                end
            end
            BUSY: begin
                if (lat_cnt == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign resp_valid = (state == RESP);
    assign resp_hs    = resp_valid && resp_ready;

    // State register; armed keeps req_ready low in the cycle right after a reset edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
        end
    end

    // Operand capture, settle countdown, result capture and completion bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            lat_cnt   <= '0;
            mul_in1   <= '0;
            mul_in2   <= '0;
            resp_id   <= '0;
            resp_data <= '0;
            resp_ovf  <= 1'b0;
            op_count  <= '0;
        end else begin
            if (accept) begin
                mul_in1 <= req_a[gnt_idx];
                mul_in2 <= req_b[gnt_idx];
                resp_id <= gnt_idx;
                lat_cnt <= 4'(MUL_LAT);
            end
            if (state == BUSY) begin
                lat_cnt <= lat_cnt - 4'd1;
                if (lat_cnt == 4'd1) begin
                    resp_data <= mul_out[2*WIDTH-1:0];
                    resp_ovf  <= mul_out[2*WIDTH];
                end
            end
            if (resp_hs) begin
                rr_ptr   <= (resp_id == IDW'(NREQ - 1)) ? '0 : resp_id + IDW'(1);
                op_count <= op_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mul_share_sched.sv
// tb/tb_mul_share_sched.sv - directed self-checking bench for mul_share_sched
module tb_mul_share_sched;

    localparam int W = 8;
    localparam int N = 4;
    localparam int L = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N-1:0][W-1:0] req_a;
    logic [N-1:0][W-1:0] req_b;
    logic [W-1:0]       mul_in1;
    logic [W-1:0]       mul_in2;
    logic [2*W:0]       mul_out;
    logic               resp_valid;
    logic               resp_ready;
    logic [1:0]         resp_id;
    logic [2*W-1:0]     resp_data;
    logic               resp_ovf;
    logic [15:0]        op_count;
    logic               force_ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int gid[5];
    int gcyc[5];
    int exp_order[5];

    always #5 clk = ~clk;

    // Behavioural shared multiplier; bit 16 can be driven high to exercise resp_ovf.
    assign mul_out = {force_ovf, 16'(mul_in1) * 16'(mul_in2)};

    mul_share_sched #(.WIDTH(W), .NREQ(N), .MUL_LAT(L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .mul_in1    (mul_in1),
        .mul_in2    (mul_in2),
        .mul_out    (mul_out),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_ovf   (resp_ovf),
        .op_count   (op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One request from the idle state through its response, resp_ready held high.
    task automatic do_op(input string tag, input logic [3:0] v, input logic [3:0] exp_rdy,
                         input int exp_id, input logic [15:0] exp_data, input logic exp_ovf);
        int n;
        @(negedge clk);
        req_valid = v;
        #1;
        chk({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
        @(negedge clk);
        req_valid = '0;
        n = 1;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'(L + 1));
        chk({tag, ".data"}, 32'(resp_data), 32'(exp_data));
        chk({tag, ".id"}, 32'(resp_id), 32'(exp_id));
        chk({tag, ".ovf"}, 32'(resp_ovf), 32'(exp_ovf));
        @(negedge clk);
        chk({tag, ".done"}, 32'(resp_valid), 32'(0));
    endtask

    initial begin
        int ng;
        int nr;
        int cyc;
        int n;
        int seen;
        exp_order = '{0, 1, 2, 3, 0};
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        force_ovf  = 1'b0;
        req_a      = '0;
        req_b      = '0;

        // Reset values, with requests present to show req_ready stays low.
        repeat (2) @(negedge clk);
        req_valid = 4'hF;
        #1;
        chk("reset.ctrl", 32'({resp_valid, req_ready, resp_id, resp_ovf}), 32'(0));
        chk("reset.data", {mul_in1, mul_in2, resp_data}, 32'(0));
        chk("reset.opcnt", 32'(op_count), 32'(0));
        req_valid = '0;
        rst_n     = 1'b1;
        @(negedge clk);

        // Single operation.
        req_a[0] = 8'h0F;
        req_b[0] = 8'h11;
        do_op("single", 4'b0001, 4'b0001, 0, 16'h00FF, 1'b0);
        chk("single.opcnt", 32'(op_count), 32'(1));

        // Round-robin with all requesters held valid.
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_a[i] = 8'(i * 16 + 3);
            req_b[i] = 8'(i * 7 + 5);
        end
        ng  = 0;
        nr  = 0;
        cyc = 0;
        @(negedge clk);
        req_valid = 4'hF;
        while (nr < 5 && cyc < 60) begin
            #1;
            if (req_ready != '0 && ng < 5) begin
                for (int j = 0; j < N; j++) begin
                    if (req_ready[j]) gid[ng] = j;
                end
                gcyc[ng] = cyc;
                ng++;
            end
            if (resp_valid) begin
                chk("rr.id", 32'(resp_id), 32'(gid[nr]));
                chk("rr.data", 32'(resp_data), 32'(16'(req_a[gid[nr]]) * 16'(req_b[gid[nr]])));
                nr++;
                if (nr == 5) req_valid = '0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("rr.responses", 32'(nr), 32'(5));
        for (int k = 0; k < 5; k++) begin
            chk("rr.order", 32'(gid[k]), 32'(exp_order[k]));
        end
        for (int k = 1; k < 5; k++) begin
            chk("rr.spacing", 32'(gcyc[k] - gcyc[k-1]), 32'(L + 2));
        end
        chk("rr.opcnt", 32'(op_count), 32'(5));

        // Backpressure: rr_ptr is 1; inputs churn while the result is held.
        req_a[1]   = 8'hFF;
        req_b[1]   = 8'hFF;
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        chk("bp.ready", 32'(req_ready), 32'(4'b0010));
        @(negedge clk);
        req_valid = 4'hF;
        req_a[1]  = 8'h12;
        chk("bp.operands", 32'({mul_in1, mul_in2}), 32'(16'hFFFF));
        n = 1;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            req_b[1] = 8'(n);
            n++;
        end
        chk("bp.latency", 32'(n), 32'(L + 1));
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("bp.hold", {resp_valid, resp_ovf, resp_id, resp_data, req_ready, mul_in1},
                {1'b1, 1'b0, 2'd1, 16'hFE01, 4'b0000, 8'hFF});
            @(negedge clk);
            req_b[1] = 8'(k + 40);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp.release", 32'(resp_valid), 32'(1));
        @(negedge clk);
        #1;
        chk("bp.idle", 32'({resp_valid, req_ready}), 32'(5'b0_0100));
        req_valid = '0;
        chk("bp.opcnt", 32'(op_count), 32'(6));

        // Pointer wrap and skip over idle requesters.
        req_a[2] = 8'd3;
        req_b[2] = 8'd5;
        do_op("ptr3", 4'b0100, 4'b0100, 2, 16'd15, 1'b0);
        req_a[0] = 8'd7;
        req_b[0] = 8'd9;
        do_op("wrap", 4'b0101, 4'b0001, 0, 16'd63, 1'b0);
        do_op("skip", 4'b0101, 4'b0100, 2, 16'd15, 1'b0);
        chk("skip.opcnt", 32'(op_count), 32'(9));

        // Overflow bit from the multiplier.
        force_ovf = 1'b1;
        req_a[3]  = 8'hFF;
        req_b[3]  = 8'hFF;
        do_op("ovf", 4'b1000, 4'b1000, 3, 16'hFE01, 1'b1);
        force_ovf = 1'b0;

        // Reset while BUSY drops the operation.
        req_a[3] = 8'd2;
        req_b[3] = 8'd3;
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        chk("rstbusy.ready", 32'(req_ready), 32'(4'b1000));
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b0;
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        chk("rstbusy.ctrl", 32'({resp_valid, req_ready, resp_id, resp_ovf}), 32'(0));
        chk("rstbusy.data", {mul_in1, mul_in2, resp_data}, 32'(0));
        chk("rstbusy.opcnt", 32'(op_count), 32'(0));
        req_valid = '0;
        rst_n     = 1'b1;
        seen      = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("rstbusy.noresp", 32'(seen), 32'(0));
        req_a[0] = 8'd4;
        req_b[0] = 8'd4;
        do_op("postrst", 4'hF, 4'b0001, 0, 16'd16, 1'b0);

        // 16-bit completion counter wrap.
        @(negedge clk);
        force dut.op_count = 16'hFFFF;
        @(negedge clk);
        release dut.op_count;
        #1;
        chk("wrap16.preset", 32'(op_count), 32'(16'hFFFF));
        req_a[1] = 8'h10;
        req_b[1] = 8'h10;
        do_op("wrap16", 4'b0010, 4'b0010, 1, 16'h0100, 1'b0);
        chk("wrap16.opcnt", 32'(op_count), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
